// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, talks to instruction memory over req/ready, and honours stalls and branch redirects.
module fetch_stage #(
  parameter int            N        = 64,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_ready,
  input  logic [31:0]   imem_rdata,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [N-1:0]  redirect_pc,
  output logic          ifid_valid,
  output logic [N-1:0]  ifid_pc,
  output logic [31:0]   ifid_instr,
  output logic [10:0]   ifid_op
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, stateNext;

  logic [N-1:0]  pc_p0, pcNext;
  logic [N-1:0]  drainAddr, drainNext;
  logic [N-1:0]  skidPc_p0;
  logic [31:0]   skidInstr_p0;
  logic          skidLoad;

  logic          vld_p1, vldNext;
  logic [N-1:0]  ifidPc_p1, ifidPcNext;
  logic [31:0]   ifidInstr_p1, ifidInstrNext;

  logic [N-1:0]  redirTarget;
  logic [N-1:0]  seqPc;

  function automatic logic [N-1:0] alignPc(input logic [N-1:0] addr);
    return addr & {{(N-2){1'b1}}, 2'b00};
  endfunction

  // Sequential PC wraps silently modulo 2^N.
  function automatic logic [N-1:0] incrPc(input logic [N-1:0] addr);
    return addr + {{(N-3){1'b0}}, 3'b100};
  endfunction

  assign redirTarget = alignPc(redirect_pc);
  assign seqPc       = incrPc(pc_p0);

  // Request/address depend only on registered state (and reset), never on stall/redirect/ready.
  assign imem_req  = ~reset & (state != HOLD);
  assign imem_addr = (state == DRAIN) ? drainAddr : pc_p0;

  always_comb begin
    stateNext     = state;
    pcNext        = pc_p0;
    drainNext     = drainAddr;
    skidLoad      = 1'b0;
    vldNext       = vld_p1;
    ifidPcNext    = ifidPc_p1;
    ifidInstrNext = ifidInstr_p1;

    unique case (state)
      FETCH: begin
        if (redirect_valid) begin
          pcNext  = redirTarget;
          vldNext = 1'b0;
          if (!imem_ready) begin
            drainNext = pc_p0;
            stateNext = DRAIN;
          end
        end else if (imem_ready && !stall) begin
          vldNext       = 1'b1;
          ifidPcNext    = pc_p0;
          ifidInstrNext = imem_rdata;
          pcNext        = seqPc;
        end else if (imem_ready) begin
          skidLoad  = 1'b1;
          pcNext    = seqPc;
          stateNext = HOLD;
        end else if (!stall) begin
          vldNext = 1'b0;
        end
      end

      HOLD: begin
        if (redirect_valid) begin
          pcNext    = redirTarget;
          vldNext   = 1'b0;
          stateNext = FETCH;
        end else if (!stall) begin
          vldNext       = 1'b1;
          ifidPcNext    = skidPc_p0;
          ifidInstrNext = skidInstr_p0;
          stateNext     = FETCH;
        end
      end

      DRAIN: begin
        // The abandoned request must complete before the target can be issued.
        if (redirect_valid) begin
          pcNext  = redirTarget;
          vldNext = 1'b0;
        end else if (imem_ready) begin
          stateNext = FETCH;
        end
      end

      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  // Control and IF/ID state; IF/ID is cleared so the decoder sees an all-zero opcode in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      pc_p0        <= RESET_PC;
      vld_p1       <= 1'b0;
      ifidPc_p1    <= '0;
      ifidInstr_p1 <= '0;
    end else begin
      state        <= stateNext;
      pc_p0        <= pcNext;
      vld_p1       <= vldNext;
      ifidPc_p1    <= ifidPcNext;
      ifidInstr_p1 <= ifidInstrNext;
    end
  end

  // Skid and drain address are pure data; their contents only matter once the FSM selects them.
  always_ff @(posedge clk) begin
    drainAddr <= drainNext;
    if (skidLoad) begin
      skidPc_p0    <= pc_p0;
      skidInstr_p0 <= imem_rdata;
    end
  end

  // IF/ID boundary
  assign ifid_valid = vld_p1;
  assign ifid_pc    = ifidPc_p1;
  assign ifid_instr = ifidInstr_p1;
  assign ifid_op    = ifidInstr_p1[31:21];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stream, wait states, stall/HOLD, redirect/DRAIN, reset and PC wrap.
module tb_fetch_stage;

  localparam int N = 64;

  logic          clk;
  logic          reset;
  logic          imem_req;
  logic [N-1:0]  imem_addr;
  logic          imem_ready;
  logic [31:0]   imem_rdata;
  logic          stall;
  logic          redirect_valid;
  logic [N-1:0]  redirect_pc;
  logic          ifid_valid;
  logic [N-1:0]  ifid_pc;
  logic [31:0]   ifid_instr;
  logic [10:0]   ifid_op;

  int numChecks = 0;
  int numFails  = 0;

  fetch_stage #(.N(N), .RESET_PC('0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .ifid_op        (ifid_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, then let the memory model present data for the new address.
  task automatic tick();
    @(posedge clk);
    #1;
    imem_rdata = 32'hF840_0000 + imem_addr[31:0];
  endtask

  task automatic checkIfid(input string tag, input logic [63:0] pc);
    checkEq({tag, "_vld"}, {63'd0, ifid_valid}, 64'd1);
    checkEq({tag, "_pc"}, ifid_pc, pc);
    checkEq({tag, "_instr"}, {32'd0, ifid_instr}, {32'd0, 32'hF840_0000 + pc[31:0]});
  endtask

  initial begin
    reset          = 1'b1;
    imem_ready     = 1'b0;
    imem_rdata     = '0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state
    repeat (3) tick();
    checkEq("rst_req", {63'd0, imem_req}, 64'd0);
    checkEq("rst_vld", {63'd0, ifid_valid}, 64'd0);
    checkEq("rst_pc", ifid_pc, 64'd0);
    checkEq("rst_instr", {32'd0, ifid_instr}, 64'd0);
    checkEq("rst_op", {53'd0, ifid_op}, 64'd0);
    reset = 1'b0;
    #1;
    checkEq("first_req", {63'd0, imem_req}, 64'd1);
    checkEq("first_addr", imem_addr, 64'd0);

    // Zero-wait stream: one instruction per cycle, LDUR opcode
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkIfid("stream", 64'(4 * i));
      checkEq("stream_op", {53'd0, ifid_op}, 64'h7C2);
    end

    // Stall captured into skid at pc 0x10, held 4 cycles
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkEq("hold_req", {63'd0, imem_req}, 64'd0);
      checkIfid("hold_frozen", 64'h0C);
    end
    stall = 1'b0;
    tick();
    checkIfid("release", 64'h10);
    checkEq("release_req", {63'd0, imem_req}, 64'd1);
    checkEq("release_addr", imem_addr, 64'h14);
    tick();
    checkIfid("after_release", 64'h14);

    // Wait states: ready every third cycle
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 2; w++) begin
        imem_ready = 1'b0;
        tick();
        checkEq("wait_vld", {63'd0, ifid_valid}, 64'd0);
        checkEq("wait_addr", imem_addr, 64'(32'h18 + 4 * k));
      end
      imem_ready = 1'b1;
      tick();
      checkIfid("wait_resp", 64'(32'h18 + 4 * k));
    end

    // Redirect while the 0x20 request is pending
    imem_ready = 1'b0;
    tick();
    checkEq("pend_addr", imem_addr, 64'h20);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h103;
    tick();
    redirect_valid = 1'b0;
    checkEq("drain_req", {63'd0, imem_req}, 64'd1);
    checkEq("drain_addr", imem_addr, 64'h20);
    checkEq("drain_vld", {63'd0, ifid_valid}, 64'd0);
    tick();
    checkEq("drain_addr2", imem_addr, 64'h20);
    imem_ready = 1'b1;
    tick();
    checkEq("drain_discard_vld", {63'd0, ifid_valid}, 64'd0);
    checkEq("target_addr", imem_addr, 64'h100);
    tick();
    checkIfid("target", 64'h100);

    // Redirect, stall and ready together: no HOLD, response dropped
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    stall          = 1'b1;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    checkEq("simul_vld", {63'd0, ifid_valid}, 64'd0);
    checkEq("simul_req", {63'd0, imem_req}, 64'd1);
    checkEq("simul_addr", imem_addr, 64'h200);
    tick();
    checkIfid("simul_target", 64'h200);

    // Reset while in HOLD
    stall = 1'b1;
    tick();
    checkEq("hold2_req", {63'd0, imem_req}, 64'd0);
    reset = 1'b1;
    tick();
    stall = 1'b0;
    tick();
    checkEq("rsthold_req", {63'd0, imem_req}, 64'd0);
    checkEq("rsthold_vld", {63'd0, ifid_valid}, 64'd0);
    checkEq("rsthold_pc", ifid_pc, 64'd0);
    checkEq("rsthold_instr", {32'd0, ifid_instr}, 64'd0);
    reset = 1'b0;
    #1;
    checkEq("rsthold_addr", imem_addr, 64'd0);
    checkEq("rsthold_req2", {63'd0, imem_req}, 64'd1);
    tick();
    checkIfid("rsthold_fetch", 64'd0);

    // Reset while in DRAIN
    imem_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h300;
    tick();
    redirect_valid = 1'b0;
    checkEq("drain2_addr", imem_addr, 64'h4);
    reset = 1'b1;
    tick();
    checkEq("rstdrain_req", {63'd0, imem_req}, 64'd0);
    checkEq("rstdrain_vld", {63'd0, ifid_valid}, 64'd0);
    checkEq("rstdrain_op", {53'd0, ifid_op}, 64'd0);
    reset = 1'b0;
    #1;
    checkEq("rstdrain_addr", imem_addr, 64'd0);
    imem_ready = 1'b1;
    tick();
    checkIfid("rstdrain_fetch", 64'd0);

    // PC wrap: low bits of the target ignored, then 2^N-4 -> 0
    redirect_valid = 1'b1;
    redirect_pc    = '1;
    tick();
    redirect_valid = 1'b0;
    checkEq("wrap_vld", {63'd0, ifid_valid}, 64'd0);
    checkEq("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    checkIfid("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC);
    checkEq("wrap_next_addr", imem_addr, 64'd0);
    tick();
    checkIfid("wrap_zero", 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFails);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the LEGv8 core. It sits directly upstream of the main decoder. It owns the PC and issues requests to instruction memory over a variable-latency request/ready handshake. It presents the fetched instruction, its PC and the 11-bit opcode field `instr[31:21]` to the decode stage, and supports hazard-unit stalls and branch redirects with flush.

## Interface
- `N`, default 64: PC and address width.
- `RESET_PC`, default 0: first fetch address after reset.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `imem_req`  out  1: fetch request is active.
- `imem_addr`  out  N: fetch address; held stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready`  in  1: response accepted this cycle; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32: instruction word.
- `stall`  in  1: the hazard unit orders the IF/ID register and PC to hold.
- `redirect_valid`  in  1: a taken branch (CBZ/CBNZ resolution) redirects fetch.
- `redirect_pc`  in  N: branch target; bits [1:0] are ignored and treated as 00.
- `ifid_valid`  out  1: IF/ID holds a live instruction.
- `ifid_pc`  out  N: PC of the instruction in IF/ID.
- `ifid_instr`  out  32: instruction in IF/ID.
- `ifid_op`  out  11: `ifid_instr[31:21]`, wired to the decoder `Op` input.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `drain_addr`: address of an abandoned in-flight request.
  - skid buffer: `skid_instr`, `skid_pc`.
  - IF/ID: valid, pc, instr.
  - FSM state.
- FSM states: FETCH, HOLD, DRAIN. `imem_req` is a function of state only: 1 in FETCH and DRAIN, 0 in HOLD. `imem_addr` is `pc` in FETCH and `drain_addr` in DRAIN.
- FETCH:
  - `imem_ready`=1, `stall`=0, no redirect: IF/ID is loaded with {1, `pc`, `imem_rdata`}; `pc` <= `pc`+4; stay in FETCH.
  - `imem_ready`=1, `stall`=1, no redirect: skid is loaded with {`pc`, `imem_rdata`}; `pc` <= `pc`+4; go to HOLD; IF/ID holds.
  - `imem_ready`=0: wait. IF/ID holds if `stall`=1, otherwise `ifid_valid` <= 0 (bubble).
- HOLD:
  - `stall`=1: nothing changes.
  - `stall`=0: IF/ID is loaded from the skid buffer with valid=1; go to FETCH.
- DRAIN: keep requesting `drain_addr` until `imem_ready`=1, then discard the response and go to FETCH. `pc` already holds the redirect target.
- Redirect has the highest priority, above `stall` and above `imem_ready`. In the redirect cycle:
  - `pc` <= {`redirect_pc`[N-1:2], 2'b00}.
  - `ifid_valid` <= 0.
  - Skid contents are dropped.
  - Any response arriving in that cycle is discarded.
  - From FETCH with `imem_ready`=0: `drain_addr` <= `pc`; go to DRAIN.
  - From FETCH with `imem_ready`=1, or from HOLD: go to FETCH.
  - From DRAIN: stay in DRAIN with `drain_addr` unchanged; `pc` takes the new target.
- PC arithmetic: `pc`+4 wraps modulo 2^N with no flag.
- Reset, while `reset`=1 in any state:
  - state <= FETCH; `pc` <= `RESET_PC`.
  - `ifid_valid`/`ifid_pc`/`ifid_instr` <= 0, so `ifid_op`=0 and the decoder takes its default all-zero controls.
  - `imem_req` is forced to 0 while `reset`=1.
  - A request outstanding at reset is abandoned. The memory model must tolerate this.

## Timing
- A response accepted in cycle t appears on the IF/ID outputs in cycle t+1.
- Throughput is one instruction per cycle when `imem_ready`=1 every cycle and `stall`=0.
- First `imem_req`=1 comes in the first cycle after `reset` falls, with `imem_addr`=`RESET_PC`.
- Redirect in cycle t:
  - Without drain: first request to the target is in cycle t+1, and the earliest target instruction in IF/ID is at t+2.
  - With drain: the target request follows the cycle in which the drained response is accepted.
- A stall never drops an instruction.
- `ifid_*` are held bit-exact while `stall`=1.
- No combinational path from `stall`, `redirect_*` or `imem_ready` to `imem_req` or `imem_addr`.

## Test plan
- Zero-wait stream: reset, `RESET_PC`=0, `imem_ready` held at 1, `imem_rdata`=0xF8400000 + addr. Expected: `ifid_pc` = 0, 4, 8, … on consecutive cycles, and `ifid_op` = 0x7C2 (LDUR) every cycle.
- Wait states: `imem_ready` asserted every 3rd cycle. Expected: `imem_addr` stable across waits, one bubble (`ifid_valid`=0) per wait cycle, no PC skipped.
- Stall into HOLD:
  - Setup: `stall`=1 for 4 cycles starting when `imem_ready`=1 at pc=0x10.
  - Expected during stall: IF/ID frozen, `imem_req`=0 after the capture, `pc` advanced to 0x14.
  - Expected after release: IF/ID shows pc 0x10, followed by 0x14.
- Redirect while waiting: request to 0x20 pending, then `redirect_valid`=1 with `redirect_pc`=0x103.
  - Expected: DRAIN keeps `imem_addr`=0x20 until ready and the 0x20 response is discarded.
  - Expected: the next request is 0x100 and `ifid_pc`=0x100 is the next valid entry.
- Simultaneous events: `redirect_valid`, `stall` and `imem_ready` all 1 in the same cycle. Expected: response discarded, `ifid_valid`=0 next cycle, next fetch at the target, no HOLD entry.
- Reset mid-operation: `reset` during DRAIN or HOLD. Expected: all `ifid_*`=0 and `imem_req`=0 during reset, then a fetch from `RESET_PC`. PC wrap case: `pc`=2^N−4 continues to 0.
